// File: rtl/rf_pkg.sv
// Shared types and helpers for the rf_multiport register file.
package rf_pkg;

  typedef enum logic {
    RF_CLEAR,
    RF_RUN
  } rf_state_t;

  localparam int unsigned RF_ZERO_ADDR = 0;

  // Upper bound on write ports the arbitration helper can handle.
  localparam int unsigned RF_MAX_PORTS = 16;
  localparam int unsigned RF_PORT_W    = 4;

  typedef struct packed {
    logic                 hit;
    logic [RF_PORT_W-1:0] port;
  } rf_sel_t;

  // Highest-index set bit of a per-write-port match vector; shared by write
  // arbitration and bypass so both resolve multi-port hits identically.
  function automatic rf_sel_t rf_hi_port(input logic [RF_MAX_PORTS-1:0] match);
    rf_sel_t sel;
    sel = '0;
    for (int unsigned i = 0; i < RF_MAX_PORTS; i++) begin
      if (match[i]) begin
        sel.hit  = 1'b1;
        sel.port = RF_PORT_W'(i);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/rf_multiport_if.sv
// Read/write port bundle between decode/writeback (master) and the register file (slave).
interface rf_multiport_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int NWR  = 2
);
  localparam int AW = $clog2(NREG);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;

  modport master (
    output rd_addr,
    input  rd_data,
    output wr_en,
    output wr_addr,
    output wr_data
  );

  modport slave (
    input  rd_addr,
    output rd_data,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );
endinterface

// File: rtl/rf_clear_seq.sv
// Clear-sweep sequencer: CLEAR/RUN FSM, sweep index and registered init_done.
module rf_clear_seq
  import rf_pkg::*;
#(
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  output logic          init_done,
  output logic          clear_we,
  output logic [AW-1:0] clear_addr
);

  localparam logic [AW-1:0] IDX_FIRST = AW'(1);
  localparam logic [AW-1:0] IDX_LAST  = AW'(NREG - 1);

  rf_state_t     state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          init_done_q, init_done_d;

  // State, sweep index and init_done registers; reset re-arms the sweep.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RF_CLEAR;
      idx_q       <= IDX_FIRST;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
    end
  end

  // Next state: sweep one register per cycle, clr restarts from index 1.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    clear_we   = 1'b0;
    clear_addr = idx_q;
    case (state_q)
      RF_CLEAR: begin
        clear_we = 1'b1;
        if (clr) begin
          idx_d = IDX_FIRST;
        end else if (idx_q == IDX_LAST) begin
          state_d = RF_RUN;
          idx_d   = IDX_FIRST;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      RF_RUN: begin
        if (clr) begin
          state_d = RF_CLEAR;
          idx_d   = IDX_FIRST;
        end
      end
      default: begin
        state_d = RF_CLEAR;
        idx_d   = IDX_FIRST;
      end
    endcase
    init_done_d = (state_d == RF_RUN);
  end

  assign init_done = init_done_q;

endmodule

// File: rtl/rf_multiport.sv
// Multi-port integer register file with r0 hardwired to zero and a clear sweep.
// Optional macro RF_BYPASS_EN: same-cycle write-to-read bypass in RUN.
module rf_multiport
  import rf_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int NWR  = 2,
  parameter int AW   = $clog2(NREG)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  output logic           init_done,
  rf_multiport_if.slave  bus
);

  logic          clear_we;
  logic [AW-1:0] clear_addr;
  logic          wr_ok;

  logic [AW-1:0]   raddr [NRD];
  logic [XLEN-1:0] rdata [NRD];
  logic [AW-1:0]   waddr [NWR];
  logic [XLEN-1:0] wdata [NWR];

  logic [XLEN-1:0] rf_q [NREG-1:1];
  logic [XLEN-1:0] rf_d [NREG-1:1];

  rf_clear_seq #(
    .NREG (NREG),
    .AW   (AW)
  ) u_clear_seq (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .init_done  (init_done),
    .clear_we   (clear_we),
    .clear_addr (clear_addr)
  );

  // Writes land only in RUN and lose to a simultaneous clr.
  assign wr_ok = init_done && !clr;

  // Unpack the flat port buses into per-port arrays.
  always_comb begin
    for (int unsigned k = 0; k < NRD; k++) begin
      raddr[k] = bus.rd_addr[k*AW +: AW];
    end
    for (int unsigned j = 0; j < NWR; j++) begin
      waddr[j] = bus.wr_addr[j*AW +: AW];
      wdata[j] = bus.wr_data[j*XLEN +: XLEN];
    end
  end

  // Per-register next value: sweep zeroing, else highest-index enabled writer.
  always_comb begin : wr_arb
    logic [RF_MAX_PORTS-1:0] match;
    rf_sel_t                 sel;
    for (int unsigned r = 1; r < NREG; r++) begin
      rf_d[r] = rf_q[r];
      match   = '0;
      for (int unsigned j = 0; j < NWR; j++) begin
        match[j] = wr_ok && bus.wr_en[j] && (waddr[j] == AW'(r));
      end
      sel = rf_hi_port(match);
      if (clear_we && (clear_addr == AW'(r))) begin
        rf_d[r] = '0;
      end else if (sel.hit) begin
        for (int unsigned j = 0; j < NWR; j++) begin
          if (sel.port == RF_PORT_W'(j)) rf_d[r] = wdata[j];
        end
      end
    end
  end

  // Storage array; contents are deliberately not reset, the sweep zeroes them.
  always_ff @(posedge clk) begin
    rf_q <= rf_d;
  end

  // Read muxes: zero until init_done and for r0, optional same-cycle bypass.
  always_comb begin : rd_mux
`ifdef RF_BYPASS_EN
    logic [RF_MAX_PORTS-1:0] match;
    rf_sel_t                 sel;
`endif
    for (int unsigned k = 0; k < NRD; k++) begin
      rdata[k] = '0;
      if (init_done && (raddr[k] != AW'(RF_ZERO_ADDR))) begin
        for (int unsigned r = 1; r < NREG; r++) begin
          if (raddr[k] == AW'(r)) rdata[k] = rf_q[r];
        end
`ifdef RF_BYPASS_EN
        match = '0;
        for (int unsigned j = 0; j < NWR; j++) begin
          match[j] = wr_ok && bus.wr_en[j] && (waddr[j] == raddr[k]);
        end
        sel = rf_hi_port(match);
        if (sel.hit) begin
          for (int unsigned j = 0; j < NWR; j++) begin
            if (sel.port == RF_PORT_W'(j)) rdata[k] = wdata[j];
          end
        end
`endif
      end
    end
  end

  // Repack read data onto the flat output bus.
  always_comb begin
    bus.rd_data = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      bus.rd_data[k*XLEN +: XLEN] = rdata[k];
    end
  end

endmodule

// File: tb/tb_rf_multiport.sv
// Directed self-checking bench for rf_multiport (default 32x32, 2R/2W).
module tb_rf_multiport;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int NWR  = 2;
  localparam int AW   = 5;

  logic clk = 1'b0;
  logic rst;
  logic clr;
  logic init_done;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int          n;
  logic [31:0] exp_v;

  rf_multiport_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) bus ();

  rf_multiport #(
    .XLEN (XLEN),
    .NREG (NREG),
    .NRD  (NRD),
    .NWR  (NWR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .init_done (init_done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rdchk(input string tag, input int p, input logic [AW-1:0] a,
                       input logic [31:0] exp);
    bus.rd_addr[p*AW +: AW] = a;
    #1;
    chk(tag, bus.rd_data[p*XLEN +: XLEN], exp);
  endtask

  task automatic wr(input int p, input logic en, input logic [AW-1:0] a, input logic [31:0] d);
    bus.wr_en[p]                = en;
    bus.wr_addr[p*AW +: AW]     = a;
    bus.wr_data[p*XLEN +: XLEN] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Counts rising edges until init_done is seen high, bounded at 100.
  task automatic count_to_run(output int cnt);
    cnt = 0;
    do begin
      @(posedge clk);
      #1;
      cnt++;
    end while (!init_done && cnt < 100);
  endtask

  initial begin
    rst         = 1'b0;
    clr         = 1'b0;
    bus.wr_en   = '0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_addr = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    chk("rst_init_done", 32'(init_done), 32'd0);
    rdchk("rst_rd0", 0, 5'd5, 32'h0);
    rdchk("rst_rd1", 1, 5'd31, 32'h0);

    // Sweep after reset
    rst = 1'b1;
    count_to_run(n);
    chk("sweep_edges", 32'(n), 32'd31);
    for (int a = 0; a < NREG; a++) begin
      rdchk("sweep_zero", a % 2, AW'(a), 32'h0);
    end
    tick();

    // Basic write, and a write to r0 on the other port
    wr(0, 1'b1, 5'd5, 32'hDEADBEEF);
    wr(1, 1'b1, 5'd0, 32'h00001234);
    tick();
    bus.wr_en = '0;
    rdchk("wr_r5", 0, 5'd5, 32'hDEADBEEF);
    rdchk("wr_r0", 1, 5'd0, 32'h0);

    // Conflict: highest port wins
    wr(0, 1'b1, 5'd7, 32'h00001111);
    wr(1, 1'b1, 5'd7, 32'h00002222);
    tick();
    bus.wr_en = '0;
    rdchk("conflict_r7", 1, 5'd7, 32'h00002222);

    // Port 1 disabled at same address: port 0 lands
    wr(0, 1'b1, 5'd10, 32'h0000000A);
    wr(1, 1'b0, 5'd10, 32'h0000000B);
    tick();
    bus.wr_en = '0;
    rdchk("lone_p0_r10", 0, 5'd10, 32'h0000000A);

    // Bypass, single writer
    wr(0, 1'b1, 5'd9, 32'h11111111);
    tick();
    wr(0, 1'b1, 5'd9, 32'hCAFE0001);
`ifdef RF_BYPASS_EN
    exp_v = 32'hCAFE0001;
`else
    exp_v = 32'h11111111;
`endif
    rdchk("byp_r9_p0", 0, 5'd9, exp_v);
    rdchk("byp_r9_p1", 1, 5'd9, exp_v);
    tick();
    bus.wr_en = '0;
    rdchk("after_r9", 0, 5'd9, 32'hCAFE0001);

    // Bypass, two writers to one register
    wr(0, 1'b1, 5'd11, 32'hAAAA0000);
    wr(1, 1'b1, 5'd11, 32'hBBBB0000);
`ifdef RF_BYPASS_EN
    exp_v = 32'hBBBB0000;
`else
    exp_v = 32'h0;
`endif
    rdchk("byp_r11", 0, 5'd11, exp_v);
    tick();
    bus.wr_en = '0;
    rdchk("after_r11", 0, 5'd11, 32'hBBBB0000);

    // Write to r0 never bypasses
    wr(1, 1'b1, 5'd0, 32'h5A5A5A5A);
    rdchk("byp_r0", 0, 5'd0, 32'h0);
    tick();
    bus.wr_en = '0;

    // clr mid-RUN with a simultaneous write
    wr(0, 1'b1, 5'd3, 32'h00000077);
    tick();
    wr(0, 1'b1, 5'd3, 32'h00000055);
    clr = 1'b1;
    rdchk("clr_no_byp", 0, 5'd3, 32'h00000077);
    @(posedge clk);
    #1;
    clr       = 1'b0;
    bus.wr_en = '0;
    chk("clr_init_fall", 32'(init_done), 32'd0);
    count_to_run(n);
    chk("clr_sweep_edges", 32'(n), 32'd31);
    rdchk("clr_r3", 0, 5'd3, 32'h0);
    rdchk("clr_r5", 1, 5'd5, 32'h0);
    tick();

    // Reset mid-sweep at idx=10, writes attempted throughout
    wr(0, 1'b1, 5'd4, 32'h00000099);
    tick();
    bus.wr_en = '0;
    rdchk("pre_r4", 0, 5'd4, 32'h00000099);
    rst = 1'b0;
    #2;
    rst = 1'b1;
    wr(0, 1'b1, 5'd2, 32'h0000BAD0);
    wr(1, 1'b1, 5'd4, 32'h0000BAD1);
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_init_done", 32'(init_done), 32'd0);
    rdchk("midrst_rd", 1, 5'd4, 32'h0);
    #1;
    rst = 1'b1;
    count_to_run(n);
    bus.wr_en = '0;
    chk("midrst_sweep_edges", 32'(n), 32'd31);
    rdchk("midrst_r2", 0, 5'd2, 32'h0);
    rdchk("midrst_r4", 1, 5'd4, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
